// File: rtl/axi_sram_pkg.sv
// Shared types and constants for the AXI-to-SRAM responder.
package axi_sram_pkg;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_VALID} r_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Offset is (addr - base) with 32-bit wrap, so addresses below base land far above span.
  function automatic logic in_window(input logic [31:0] off, input logic [31:0] span);
    return off < span;
  endfunction

endpackage

// File: rtl/axi_sram_mem.sv
// 1R1W SRAM, 32-bit words, byte-enable write, registered read port.
module axi_sram_mem #(
  parameter int unsigned MEM_WORDS = 16384,
  parameter int unsigned AW        = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [3:0]    wr_strb,
  input  logic          rd_en,
  input  logic          rd_hit,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [0:MEM_WORDS-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // A miss loads zero so the read data register doubles as the AXI rdata output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= rd_hit ? mem[rd_addr] : '0;
  end

endmodule

// File: rtl/axi_ddr_sram_slave.sv
// AXI4 INCR-burst responder backed by on-chip SRAM; independent read and write FSMs.
module axi_ddr_sram_slave
  import axi_sram_pkg::*;
#(
  parameter int unsigned AXI_ID_WIDTH = 4,
  parameter int unsigned MEM_WORDS    = 16384,
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [AXI_ID_WIDTH-1:0] awid,
  input  logic [31:0]             awaddr,
  input  logic [7:0]              awlen,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [31:0]             wdata,
  input  logic [3:0]              wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [AXI_ID_WIDTH-1:0] bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [AXI_ID_WIDTH-1:0] arid,
  input  logic [31:0]             araddr,
  input  logic [7:0]              arlen,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [AXI_ID_WIDTH-1:0] rid,
  output logic [31:0]             rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int unsigned AW   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [31:0] SPAN = 32'(4 * MEM_WORDS);

  w_state_t    w_state, w_state_nxt;
  logic [31:0] w_addr;
  logic [7:0]  w_len, w_cnt;
  logic        w_err;
  logic [31:0] w_off_c;
  logic        w_hit_c, aw_hs_c, w_hs_c, b_hs_c, w_last_c;

  r_state_t    r_state, r_state_nxt;
  logic [31:0] r_addr;
  logic [7:0]  r_len, r_cnt;
  logic [31:0] r_off_c;
  logic        r_hit_c, ar_hs_c, r_hs_c;

  assign aw_hs_c  = awready & awvalid;
  assign w_hs_c   = wready & wvalid;
  assign b_hs_c   = bvalid & bready;
  assign w_last_c = (w_cnt == w_len);
  assign w_off_c  = w_addr - BASE_ADDR;
  assign w_hit_c  = in_window(w_off_c, SPAN);

  assign ar_hs_c  = arready & arvalid;
  assign r_hs_c   = rvalid & rready;
  assign r_off_c  = r_addr - BASE_ADDR;
  assign r_hit_c  = in_window(r_off_c, SPAN);

  // Write FSM next state
  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs_c)             w_state_nxt = W_DATA;
      W_DATA:  if (w_hs_c && w_last_c)  w_state_nxt = W_RESP;
      W_RESP:  if (b_hs_c)              w_state_nxt = W_IDLE;
      default:                          w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      awready <= 1'b1;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
      bid     <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
    end else begin
      w_state <= w_state_nxt;
      awready <= (w_state_nxt == W_IDLE);
      wready  <= (w_state_nxt == W_DATA);
      bvalid  <= (w_state_nxt == W_RESP);
      if (aw_hs_c) begin
        bid    <= awid;
        w_addr <= awaddr;
        w_len  <= awlen;
        w_cnt  <= '0;
        w_err  <= 1'b0;
      end
      if (w_hs_c) begin
        w_addr <= w_addr + 32'd4;
        w_cnt  <= w_cnt + 8'd1;
        if (!w_hit_c) w_err <= 1'b1;
        if (w_last_c) bresp <= (w_err || !w_hit_c) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // Read FSM next state
  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs_c) r_state_nxt = R_FETCH;
      R_FETCH:              r_state_nxt = R_VALID;
      R_VALID: if (r_hs_c)  r_state_nxt = rlast ? R_IDLE : R_FETCH;
      default:              r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rresp   <= RESP_OKAY;
      rlast   <= 1'b0;
      rid     <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= r_state_nxt;
      arready <= (r_state_nxt == R_IDLE);
      rvalid  <= (r_state_nxt == R_VALID);
      if (ar_hs_c) begin
        rid    <= arid;
        r_addr <= araddr;
        r_len  <= arlen;
        r_cnt  <= '0;
      end
      // Beat attributes are latched with the SRAM read so they stay stable under rready=0.
      if (r_state == R_FETCH) begin
        rresp <= r_hit_c ? RESP_OKAY : RESP_SLVERR;
        rlast <= (r_cnt == r_len);
      end
      if (r_hs_c) begin
        r_addr <= r_addr + 32'd4;
        r_cnt  <= r_cnt + 8'd1;
      end
    end
  end

  axi_sram_mem #(
    .MEM_WORDS (MEM_WORDS),
    .AW        (AW)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (w_hs_c & w_hit_c),
    .wr_addr (w_off_c[AW+1:2]),
    .wr_data (wdata),
    .wr_strb (wstrb),
    .rd_en   (r_state == R_FETCH),
    .rd_hit  (r_hit_c),
    .rd_addr (r_off_c[AW+1:2]),
    .rd_data (rdata)
  );

endmodule

// File: tb/tb_axi_ddr_sram_slave.sv
// Directed self-checking bench for axi_ddr_sram_slave.
module tb_axi_ddr_sram_slave;

  localparam int unsigned IDW   = 4;
  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam logic [31:0] LIMIT = 32'h1001_0000;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [IDW-1:0] awid = '0, arid = '0, bid, rid;
  logic [31:0]    awaddr = '0, araddr = '0, wdata = '0, rdata;
  logic [7:0]     awlen = '0, arlen = '0;
  logic [3:0]     wstrb = '0;
  logic           awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic           awready, wready, bvalid, arready, rvalid, rlast;
  logic [1:0]     bresp, rresp;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0]    wr_d [16];
  logic [3:0]     wr_s [16];
  logic [31:0]    rd_d [16];
  logic [1:0]     rd_r [16];
  logic           rd_l [16];
  logic [IDW-1:0] rd_id[16];
  int             rd_lat, rd_beats, b_lat;
  logic           rd_stable;
  logic [IDW-1:0] b_id;
  logic [1:0]     b_resp;

  axi_ddr_sram_slave #(.AXI_ID_WIDTH(IDW), .MEM_WORDS(16384), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Drivers: all start and end on a falling edge.
  task automatic aw_send(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [7:0] len);
    int n = 0;
    awid = id; awaddr = addr; awlen = len; awvalid = 1'b1;
    while (awready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin n_tests++; n_fail++; $display("FAIL aw_timeout awready=%b required 1", awready); end
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    wdata = d; wstrb = s; wvalid = 1'b1;
    while (wready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin n_tests++; n_fail++; $display("FAIL w_timeout wready=%b required 1", wready); end
    @(negedge clk);
    wvalid = 1'b0;
  endtask

  task automatic w_burst(input logic [7:0] len);
    for (int i = 0; i <= int'(len); i++) w_beat(wr_d[i], wr_s[i]);
    b_lat = 1;
    while (bvalid !== 1'b1 && b_lat < 50) begin @(negedge clk); b_lat++; end
  endtask

  task automatic b_take();
    b_id = bid; b_resp = bresp;
    if (bvalid !== 1'b1) begin n_tests++; n_fail++; $display("FAIL b_timeout bvalid=%b required 1", bvalid); end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic wr_txn(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [7:0] len);
    aw_send(id, addr, len);
    w_burst(len);
    b_take();
  endtask

  task automatic rd_txn(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                        input int stall_beat, input int stall_cyc);
    int n = 0;
    arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
    while (arready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    arvalid = 1'b0;
    rd_lat = 1;
    while (rvalid !== 1'b1 && rd_lat < 50) begin @(negedge clk); rd_lat++; end
    rd_stable = 1'b1;
    rd_beats  = 0;
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      while (rvalid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) begin n_tests++; n_fail++; $display("FAIL r_timeout beat=%0d rvalid=%b required 1", i, rvalid); end
      rd_d[i] = rdata; rd_r[i] = rresp; rd_l[i] = rlast; rd_id[i] = rid;
      if (i == stall_beat) begin
        repeat (stall_cyc) begin
          @(negedge clk);
          if (rvalid !== 1'b1 || rdata !== rd_d[i] || rlast !== rd_l[i] || rresp !== rd_r[i]) rd_stable = 1'b0;
        end
      end
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      rd_beats++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests++;
    if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b110000) begin
      n_fail++; $display("FAIL reset_handshake got=%b required 110000", {awready, arready, wready, bvalid, rvalid, rlast});
    end
    n_tests++;
    if ({bresp, rresp, bid, rid} !== 12'h000) begin
      n_fail++; $display("FAIL reset_resp_id got=%h required 000", {bresp, rresp, bid, rid});
    end
    n_tests++;
    if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h required 0", rdata); end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({awready, arready, wready, bvalid, rvalid} !== 5'b11000) begin
      n_fail++; $display("FAIL post_reset_idle got=%b required 11000", {awready, arready, wready, bvalid, rvalid});
    end
  endtask

  task automatic test_single();
    wr_d[0] = 32'hDEAD_BEEF; wr_s[0] = 4'hF;
    wr_txn(4'd3, 32'h1000_0010, 8'd0);
    n_tests++; if (b_lat !== 1) begin n_fail++; $display("FAIL single_b_latency got=%0d required 1", b_lat); end
    n_tests++; if (b_id !== 4'd3) begin n_fail++; $display("FAIL single_bid got=%h required 3", b_id); end
    n_tests++; if (b_resp !== 2'b00) begin n_fail++; $display("FAIL single_bresp got=%b required 00", b_resp); end
    rd_txn(4'd5, 32'h1000_0010, 8'd0, -1, 0);
    n_tests++; if (rd_lat !== 2) begin n_fail++; $display("FAIL single_r_latency got=%0d required 2", rd_lat); end
    n_tests++; if (rd_d[0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_rdata got=%h required deadbeef", rd_d[0]); end
    n_tests++; if (rd_l[0] !== 1'b1 || rd_r[0] !== 2'b00) begin
      n_fail++; $display("FAIL single_rlast_rresp got=%b/%b required 1/00", rd_l[0], rd_r[0]);
    end
    n_tests++; if (rd_id[0] !== 4'd5) begin n_fail++; $display("FAIL single_rid got=%h required 5", rd_id[0]); end
    n_tests++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL single_no_extra_beat rvalid=%b required 0", rvalid); end
  endtask

  task automatic test_burst_strb();
    logic [31:0] exp_d [4];
    exp_d[0] = 32'd1; exp_d[1] = 32'h0000_BBBB; exp_d[2] = 32'd3; exp_d[3] = 32'd4;
    wr_d[0] = 32'h0; wr_s[0] = 4'hF;
    wr_txn(4'd1, 32'h1000_0104, 8'd0);
    wr_d[0] = 32'd1; wr_d[1] = 32'hAAAA_BBBB; wr_d[2] = 32'd3; wr_d[3] = 32'd4;
    wr_s[0] = 4'hF;  wr_s[1] = 4'b0011;       wr_s[2] = 4'hF;  wr_s[3] = 4'hF;
    wr_txn(4'd2, 32'h1000_0100, 8'd3);
    n_tests++; if (b_resp !== 2'b00 || b_id !== 4'd2) begin
      n_fail++; $display("FAIL burst_b got=%b/%h required 00/2", b_resp, b_id);
    end
    rd_txn(4'd6, 32'h1000_0100, 8'd3, -1, 0);
    n_tests++; if (rd_beats !== 4) begin n_fail++; $display("FAIL burst_beats got=%0d required 4", rd_beats); end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (rd_d[i] !== exp_d[i] || rd_l[i] !== (i == 3)) begin
        n_fail++; $display("FAIL burst_beat%0d data=%h last=%b required %h/%b", i, rd_d[i], rd_l[i], exp_d[i], (i == 3));
      end
    end
  endtask

  task automatic test_read_stall();
    logic [31:0] exp_d [4];
    exp_d[0] = 32'd1; exp_d[1] = 32'h0000_BBBB; exp_d[2] = 32'd3; exp_d[3] = 32'd4;
    rd_txn(4'd7, 32'h1000_0100, 8'd3, 1, 5);
    n_tests++; if (rd_stable !== 1'b1) begin n_fail++; $display("FAIL stall_stable got=%b required 1", rd_stable); end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (rd_d[i] !== exp_d[i] || rd_l[i] !== (i == 3) || rd_id[i] !== 4'd7) begin
        n_fail++; $display("FAIL stall_beat%0d data=%h last=%b id=%h required %h/%b/7", i, rd_d[i], rd_l[i], rd_id[i], exp_d[i], (i == 3));
      end
    end
  endtask

  task automatic test_out_of_range();
    wr_d[0] = 32'h1234_5678; wr_s[0] = 4'hF;
    wr_txn(4'd0, BASE, 8'd0);
    wr_d[0] = 32'hFFFF_FFFF;
    wr_txn(4'd9, LIMIT, 8'd0);
    n_tests++; if (b_resp !== 2'b10 || b_id !== 4'd9) begin
      n_fail++; $display("FAIL oor_write_b got=%b/%h required 10/9", b_resp, b_id);
    end
    rd_txn(4'd1, BASE, 8'd0, -1, 0);
    n_tests++; if (rd_d[0] !== 32'h1234_5678) begin n_fail++; $display("FAIL oor_sram_unchanged got=%h required 12345678", rd_d[0]); end
    rd_txn(4'd4, LIMIT, 8'd0, -1, 0);
    n_tests++; if (rd_r[0] !== 2'b10 || rd_d[0] !== 32'h0 || rd_l[0] !== 1'b1) begin
      n_fail++; $display("FAIL oor_read got=%b/%h/%b required 10/0/1", rd_r[0], rd_d[0], rd_l[0]);
    end
    wr_d[0] = 32'hCAFE_0001; wr_d[1] = 32'hCAFE_0002; wr_s[0] = 4'hF; wr_s[1] = 4'hF;
    wr_txn(4'd2, LIMIT - 32'd4, 8'd1);
    n_tests++; if (b_resp !== 2'b10) begin n_fail++; $display("FAIL edge_write_bresp got=%b required 10", b_resp); end
    rd_txn(4'd3, LIMIT - 32'd4, 8'd1, -1, 0);
    n_tests++; if (rd_d[0] !== 32'hCAFE_0001 || rd_r[0] !== 2'b00 || rd_l[0] !== 1'b0) begin
      n_fail++; $display("FAIL edge_read_beat0 got=%h/%b/%b required cafe0001/00/0", rd_d[0], rd_r[0], rd_l[0]);
    end
    n_tests++; if (rd_d[1] !== 32'h0 || rd_r[1] !== 2'b10 || rd_l[1] !== 1'b1) begin
      n_fail++; $display("FAIL edge_read_beat1 got=%h/%b/%b required 0/10/1", rd_d[1], rd_r[1], rd_l[1]);
    end
  endtask

  task automatic test_b_backpressure();
    int bad = 0;
    aw_send(4'hA, 32'h1000_0020, 8'd0);
    wr_d[0] = 32'h0BAD_F00D; wr_s[0] = 4'hF;
    w_burst(8'd0);
    repeat (10) begin
      if (bvalid !== 1'b1 || awready !== 1'b0) bad++;
      @(negedge clk);
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL bp_hold bad_cycles=%0d required 0", bad); end
    n_tests++; if (bid !== 4'hA) begin n_fail++; $display("FAIL bp_bid got=%h required a", bid); end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    n_tests++; if (awready !== 1'b1 || bvalid !== 1'b0) begin
      n_fail++; $display("FAIL bp_release awready=%b bvalid=%b required 1/0", awready, bvalid);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] exp_d [4];
    int stray = 0;
    wr_d[0] = 32'hA0; wr_d[1] = 32'hA1; wr_d[2] = 32'hA2; wr_d[3] = 32'hA3;
    for (int i = 0; i < 4; i++) wr_s[i] = 4'hF;
    wr_txn(4'd0, 32'h1000_0200, 8'd3);
    aw_send(4'd1, 32'h1000_0200, 8'd3);
    w_beat(32'hB0, 4'hF);
    w_beat(32'hB1, 4'hF);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (awready !== 1'b1 || bvalid !== 1'b0 || wready !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_state awready=%b bvalid=%b wready=%b required 1/0/0", awready, bvalid, wready);
    end
    repeat (4) begin if (bvalid !== 1'b0) stray++; @(negedge clk); end
    n_tests++; if (stray !== 0) begin n_fail++; $display("FAIL rst_mid_stray_b cycles=%0d required 0", stray); end
    exp_d[0] = 32'hB0; exp_d[1] = 32'hB1; exp_d[2] = 32'hA2; exp_d[3] = 32'hA3;
    rd_txn(4'd2, 32'h1000_0200, 8'd3, -1, 0);
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (rd_d[i] !== exp_d[i]) begin n_fail++; $display("FAIL rst_mid_word%0d got=%h required %h", i, rd_d[i], exp_d[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst_strb();
    test_read_stall();
    test_out_of_range();
    test_b_backpressure();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
